// File: rtl/maxnet_engine.sv
// -----------------------------------------------------------------------------
// maxnet_engine
//   Iterative winner-take-all (MAXNET) competition between N neurons.
//   Activations and weights are signed 5-bit fixed point with 3 fractional bits.
//   Each iteration evaluates one weight row per cycle in CALC (N cycles), then
//   commits the new activations in UPDATE. Competition stops when at most one
//   neuron is still active or the iteration cap is reached.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset, aborts any competition
//   start       begin a competition (only honoured in IDLE)
//   x_in        N signed 5-bit initial activations, neuron k at [5k+4:5k]
//   w_flat      N*N signed 5-bit weights, entry r*N+c, row r = destination
//   busy        competition in progress
//   done        one-cycle completion pulse
//   valid       exactly one surviving neuron
//   winner_idx  index of the survivor (0 when not valid)
//   winner_val  activation of the survivor (0 when not valid)
//   iter_count  iterations performed in the last / current competition
// -----------------------------------------------------------------------------
module maxnet_engine #(
  parameter int N     = 4,
  parameter int MAXIT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [5*N-1:0]         x_in,
  input  logic [5*N*N-1:0]       w_flat,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic [$clog2(N)-1:0]   winner_idx,
  output logic [4:0]             winner_val,
  output logic [3:0]             iter_count
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_UPDATE, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  // Activations are always clamped to 0..15, so they are non-negative.
  logic [4:0]    r_x  [N];
  logic [4:0]    r_nx [N];
  logic [IW-1:0] r_row;
  logic [3:0]    r_iter;
  logic          r_busy;
  logic          r_done;
  logic          r_valid;
  logic [IW-1:0] r_widx;
  logic [4:0]    r_wval;

  // Phase strobes decoded from the state
  logic w_load;
  logic w_calc;
  logic w_update;
  logic w_finish;

  // ---------------------------------------------------------------------------
  // Row datapath: weights of the current row times the (frozen) activations
  // ---------------------------------------------------------------------------
  logic [4:0]         w_wrow [N];
  logic signed [11:0] w_prod [N];
  logic signed [11:0] w_acc;
  logic signed [11:0] w_shift;
  logic [4:0]         w_nx_val;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      assign w_wrow[gi] = w_flat[5*(int'(r_row)*N + gi) +: 5];
      // Both operands widened to the accumulator width so the product is exact.
      assign w_prod[gi] = $signed({{7{w_wrow[gi][4]}}, w_wrow[gi]}) *
                          $signed({7'b0, r_x[gi]});
    end
  endgenerate

  always_comb begin
    w_acc = '0;
    for (int c = 0; c < N; c++) begin
      w_acc = w_acc + w_prod[c];
    end
  end

  // Arithmetic shift floors toward -inf; the result is then clamped to 0..15.
  assign w_shift = w_acc >>> 3;

  always_comb begin
    w_nx_val = w_shift[4:0];
    if (w_shift[11]) begin
      w_nx_val = 5'd0;
    end else if (w_shift > 12'sd15) begin
      w_nx_val = 5'd15;
    end
  end

  // ---------------------------------------------------------------------------
  // Survivor bookkeeping
  // ---------------------------------------------------------------------------
  logic [N-1:0]  w_nz_nx;
  logic [N-1:0]  w_nz_x;
  logic [CW-1:0] w_cnt_nx;
  logic [CW-1:0] w_cnt_x;
  logic [IW-1:0] w_win_idx;
  logic [4:0]    w_win_val;
  logic [3:0]    w_iter_inc;
  logic          w_last_iter;

  generate
    for (gi = 0; gi < N; gi++) begin : g_nz
      assign w_nz_nx[gi] = |r_nx[gi];
      assign w_nz_x[gi]  = |r_x[gi];
    end
  endgenerate

  always_comb begin
    w_cnt_nx  = '0;
    w_cnt_x   = '0;
    w_win_idx = '0;
    w_win_val = '0;
    for (int c = 0; c < N; c++) begin
      w_cnt_nx = w_cnt_nx + CW'(w_nz_nx[c]);
      w_cnt_x  = w_cnt_x + CW'(w_nz_x[c]);
      if (w_nz_x[c]) begin
        w_win_idx = IW'(c);
        w_win_val = r_x[c];
      end
    end
  end

  assign w_iter_inc  = r_iter + 4'd1;
  assign w_last_iter = (w_cnt_nx <= CW'(1)) || (w_iter_inc == 4'(MAXIT));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_state_next = S_CALC;
      S_CALC:   if (r_row == IW'(N - 1)) w_state_next = S_UPDATE;
      S_UPDATE: w_state_next = w_last_iter ? S_DONE : S_CALC;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // FSM: output decode (phase strobes driving the datapath registers)
  always_comb begin
    w_load   = 1'b0;
    w_calc   = 1'b0;
    w_update = 1'b0;
    w_finish = 1'b0;
    unique case (r_state)
      S_IDLE:   w_load   = start;
      S_CALC:   w_calc   = 1'b1;
      S_UPDATE: w_update = 1'b1;
      S_DONE:   w_finish = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        r_x[k]  <= '0;
        r_nx[k] <= '0;
      end
      r_row   <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_widx  <= '0;
      r_wval  <= '0;
    end else begin
      r_done <= w_finish;

      if (w_load) begin
        // Negative inputs never compete; they enter as zero.
        for (int k = 0; k < N; k++) begin
          r_x[k] <= x_in[5*k+4] ? 5'd0 : x_in[5*k +: 5];
        end
        r_iter  <= '0;
        r_row   <= '0;
        r_busy  <= 1'b1;
        r_valid <= 1'b0;
        r_widx  <= '0;
        r_wval  <= '0;
      end

      if (w_calc) begin
        r_nx[r_row] <= w_nx_val;
        r_row       <= (r_row == IW'(N - 1)) ? '0 : r_row + 1'b1;
      end

      if (w_update) begin
        for (int k = 0; k < N; k++) begin
          r_x[k] <= r_nx[k];
        end
        r_iter <= w_iter_inc;
        r_row  <= '0;
      end

      if (w_finish) begin
        r_busy  <= 1'b0;
        r_valid <= (w_cnt_x == CW'(1));
        r_widx  <= (w_cnt_x == CW'(1)) ? w_win_idx : '0;
        r_wval  <= (w_cnt_x == CW'(1)) ? w_win_val : '0;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign valid      = r_valid;
  assign winner_idx = r_widx;
  assign winner_val = r_wval;
  assign iter_count = r_iter;

endmodule

// File: tb/tb_maxnet_engine.sv
// -----------------------------------------------------------------------------
// tb_maxnet_engine
//   Directed, table-driven bench for maxnet_engine. Each table row holds the
//   initial activations, the weight matrix and the hand-computed final outputs
//   and done latency. Reset-abort and start-while-busy are hand sequences.
// -----------------------------------------------------------------------------
module tb_maxnet_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] x_in;
  logic [79:0] w_flat;
  logic        busy;
  logic        done;
  logic        valid;
  logic [1:0]  winner_idx;
  logic [4:0]  winner_val;
  logic [3:0]  iter_count;

  maxnet_engine #(.N(4), .MAXIT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x_in       (x_in),
    .w_flat     (w_flat),
    .busy       (busy),
    .done       (done),
    .valid      (valid),
    .winner_idx (winner_idx),
    .winner_val (winner_val),
    .iter_count (iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] x;
    logic [79:0] w;
    int          lat;
    logic        v;
    logic [1:0]  idx;
    logic [4:0]  val;
    logic [3:0]  iter;
  } vec_t;

  localparam int NVEC  = 8;
  localparam int BOUND = 200;

  vec_t vecs [NVEC];
  int   n_tests;
  int   n_fail;

  function automatic logic [79:0] mk_w(input logic [4:0] diag, input logic [4:0] off);
    logic [79:0] w;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w[5*(r*4+c) +: 5] = (r == c) ? diag : off;
      end
    end
    return w;
  endfunction

  function automatic logic [19:0] mk_x(input logic [4:0] a0, input logic [4:0] a1,
                                       input logic [4:0] a2, input logic [4:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s case %0d: got %0d expected %0d", name, id, act, exp);
    end
  endtask

  // Start one competition, wait for done (bounded), check results and hold.
  // x_in is scrambled while busy; optionally start is re-asserted while busy.
  task automatic run_case(input int id, input vec_t v, input bit poke_start);
    int cyc;
    bit got;
    @(negedge clk);
    x_in   = v.x;
    w_flat = v.w;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", id, 32'(busy), 32'd1);
    check("iter_after_start", id, 32'(iter_count), 32'd0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < BOUND) begin
      start = (poke_start && cyc < 9) ? 1'b1 : 1'b0;
      x_in  = 20'($urandom);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_latency", id, 32'(cyc), 32'(v.lat));
    check("valid", id, 32'(valid), 32'(v.v));
    check("winner_idx", id, 32'(winner_idx), 32'(v.idx));
    check("winner_val", id, 32'(winner_val), 32'(v.val));
    check("iter_count", id, 32'(iter_count), 32'(v.iter));
    check("busy_at_done", id, 32'(busy), 32'd0);
    repeat (3) begin
      x_in = 20'($urandom);
      @(negedge clk);
    end
    check("done_pulse_width", id, 32'(done), 32'd0);
    check("hold_valid", id, 32'(valid), 32'(v.v));
    check("hold_val", id, 32'(winner_val), 32'(v.val));
    check("hold_iter", id, 32'(iter_count), 32'(v.iter));
    $display("[TB] case %0d: latency=%0d valid=%0d idx=%0d val=%0d iter=%0d",
             id, cyc, valid, winner_idx, winner_val, iter_count);
  endtask

  initial begin
    vec_t clear_v;
    bit   seen_done;

    n_tests = 0;
    n_fail  = 0;

    // Diagonal 1.0 (01000), off-diagonal -0.25 (11110) unless noted.
    vecs[0] = '{mk_x(5'b01000, 5'b00100, 5'b00010, 5'b00001), mk_w(5'b01000, 5'b11110),
                11, 1'b1, 2'd0, 5'd5, 4'd2};                       // clear winner
    vecs[1] = '{mk_x(5'b01000, 5'b01000, 5'b00000, 5'b00000), mk_w(5'b01000, 5'b11110),
                31, 1'b0, 2'd0, 5'd0, 4'd6};                       // tie annihilation
    vecs[2] = '{mk_x(5'b00000, 5'b11000, 5'b00011, 5'b10000), mk_w(5'b01000, 5'b11110),
                6, 1'b1, 2'd2, 5'd3, 4'd1};                        // single + negatives
    vecs[3] = '{mk_x(5'b01111, 5'b00000, 5'b00000, 5'b00000), mk_w(5'b01111, 5'b00000),
                6, 1'b1, 2'd0, 5'd15, 4'd1};                       // saturation
    vecs[4] = '{mk_x(5'b00000, 5'b00000, 5'b00000, 5'b00000), mk_w(5'b01000, 5'b11110),
                6, 1'b0, 2'd0, 5'd0, 4'd1};                        // all zero
    vecs[5] = '{mk_x(5'b00100, 5'b01000, 5'b00000, 5'b00000), mk_w(5'b01000, 5'b11110),
                11, 1'b1, 2'd1, 5'd6, 4'd2};                       // winner at index 1
    vecs[6] = '{mk_x(5'b01000, 5'b01000, 5'b00000, 5'b00000), mk_w(5'b01000, 5'b00000),
                76, 1'b0, 2'd0, 5'd0, 4'd15};                      // iteration cap
    vecs[7] = '{mk_x(5'b00000, 5'b00000, 5'b00000, 5'b00101), mk_w(5'b01000, 5'b11110),
                6, 1'b1, 2'd3, 5'd5, 4'd1};                        // winner at last index
    clear_v = vecs[0];

    // Reset state
    rst    = 1'b1;
    start  = 1'b0;
    x_in   = '0;
    w_flat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 0, 32'(busy), 32'd0);
    check("reset_done", 0, 32'(done), 32'd0);
    check("reset_valid", 0, 32'(valid), 32'd0);
    check("reset_idx", 0, 32'(winner_idx), 32'd0);
    check("reset_val", 0, 32'(winner_val), 32'd0);
    check("reset_iter", 0, 32'(iter_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_case(i, vecs[i], 1'b0);
    end

    // Reset abort in the third CALC cycle
    @(negedge clk);
    x_in   = clear_v.x;
    w_flat = clear_v.w;
    start  = 1'b1;
    @(posedge clk);          // start edge; CALC cycle 1 follows
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);          // CALC cycle 2 follows
    @(posedge clk);          // CALC cycle 3 follows
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 100, 32'(busy), 32'd0);
    check("abort_done", 100, 32'(done), 32'd0);
    check("abort_valid", 100, 32'(valid), 32'd0);
    check("abort_idx", 100, 32'(winner_idx), 32'd0);
    check("abort_val", 100, 32'(winner_val), 32'd0);
    check("abort_iter", 100, 32'(iter_count), 32'd0);
    seen_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_no_done", 100, 32'(seen_done), 32'd0);
    $display("[TB] case 100: reset abort, outputs cleared, activity after abort=%0d", seen_done);
    run_case(101, clear_v, 1'b0);

    // Start held during CALC and UPDATE must not disturb the competition
    run_case(102, clear_v, 1'b1);
    run_case(103, vecs[1], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
